piece_sequencer: RTL and testbench
==================================

# piece_sequencer

Serves tetrominoes one at a time to the game controller from the 7-piece random bag generator. It keeps an active bag and a prefetched spare bag, and refills the spare through the generator's `newbag`/`ready` handshake. It also implements the player hold slot. The block sits between the random bag generator and the game-state FSM.

## Interface
- `TIMEOUT`, 64: cycles to wait for `ready` after a `newbag` pulse before re-issuing it; minimum 4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `nreset`  in  1  reset, active-low, asynchronous assert; single clock, async active-low reset.
- `newbag`  out  1  one-cycle pulse requesting a fresh bag from the generator.
- `ready`  in  1  generator done flag (level); `pieces` is valid while it is high.
- `pieces`  in  21  bag contents; piece k = `pieces[3k+2:3k]`, k=0 is served first.
- `next_req`  in  1  game consumes the current piece (single-cycle strobe).
- `hold_req`  in  1  game requests a hold/swap of the current piece.
- `piece`  out  3  current piece code.
- `piece_valid`  out  1  `piece` is meaningful.
- `preview`  out  3  piece that follows `piece`.
- `preview_valid`  out  1  `preview` is meaningful.
- `hold_piece`  out  3  held piece code.
- `hold_valid`  out  1  hold slot occupied.
- `hold_used`  out  1  hold already used for the current piece.
- `bag_timeout`  out  1  sticky; set on any `TIMEOUT` expiry.

## Operation
- Storage:
  - active bag, 7x3 bits, with index `idx` 0..6 and flag `act_v`.
  - spare bag, 7x3 bits, with flag `spr_v`.
  - hold register plus `hold_valid` and `hold_used`.
- Fill FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ when `!act_v || !spr_v`.
  - REQ: `newbag`=1 for exactly one cycle; load timeout counter to 0; -> WAIT.
  - WAIT: `ready` is ignored in the first WAIT cycle. Afterwards, on `ready`=1, capture `pieces`:
    - into active if `!act_v` (set `act_v`, `idx`=0), else into spare (set `spr_v`).
    - Then -> IDLE.
  - WAIT timeout: if the counter reaches `TIMEOUT-1` without capture, set `bag_timeout` and -> REQ.
- `piece` = active[`idx`]; `piece_valid` = `act_v`.
- `preview` source:
  - active[`idx`+1] when `idx`<6, with `preview_valid` = `act_v`.
  - else spare[0], with `preview_valid` = `act_v && spr_v`.
- Accepted `next_req` (requires `piece_valid`):
  - if `idx`<6: `idx`++.
  - if `idx`==6 and `spr_v`: active <= spare, `idx`=0, `spr_v`=0.
  - if `idx`==6 and `!spr_v`: `act_v`=0.
  - Always clears `hold_used`.
- Accepted `hold_req` (requires `piece_valid && !hold_used`, and no `next_req` in the same cycle):
  - if `hold_valid`: swap active[`idx`] and the hold register.
  - else: hold <= `piece`, set `hold_valid`, then advance exactly as `next_req` does but without clearing `hold_used`.
  - Either case sets `hold_used`.
- Simultaneous `next_req` and `hold_req`: `next_req` wins; `hold_req` is dropped.
- Requests while `!piece_valid`, and `hold_req` while `hold_used`, are ignored with no state change.
- A capture into active and an accepted `next_req` can never coincide, because `act_v`=0 blocks acceptance.
- Piece code 7 is passed through unmodified; no checking.

## Timing
- Reset values:
  - `newbag`=0; FSM in IDLE.
  - `act_v`=`spr_v`=0; `idx`=0; counter=0.
  - `piece`, `preview`, `hold_piece` all =0.
  - `piece_valid`, `preview_valid`, `hold_valid`, `hold_used`, `bag_timeout` all =0.
- All outputs are registered or derived only from registers; there are no combinational paths from inputs to outputs.
- Reset release: edge 1 enters REQ; `newbag` is high after edge 2 for one cycle; WAIT follows.
- Capture: if `ready` is sampled high at edge N, `piece_valid`=1 after edge N.
  - The spare `newbag` then pulses two edges later (IDLE -> REQ -> pulse).
- `next_req`/`hold_req` sampled at edge N: outputs update after edge N. Back-to-back strobes are accepted every cycle.
- Asserting `nreset` mid-WAIT aborts the fill. After release the sequence restarts from the first `newbag`; no partial bag is retained.

## Test plan
- Reset, bag model returns `ready` 3 cycles after `newbag` with `pieces`=21'o6543210 -> exactly two `newbag` pulses; `piece`=0, `preview`=1; `piece_valid` and `preview_valid` high.
- Active 21'o6543210, spare 21'o0123456; 7 `next_req` strobes -> `piece` sequence 0,1,2,3,4,5,6,6. `preview` at `idx`=6 is 6 (spare[0]). A third `newbag` pulse follows the swap.
- Bag model withholds `ready` for spare refill, 7 `next_req` -> `piece_valid`=0 after the 7th; further `next_req` ignored. Releasing `ready` with 21'o1111111 -> `piece`=1, `idx`=0.
- Hold: `piece`=2, hold empty, `hold_req` -> `hold_piece`=2, `piece`=3, `hold_used`=1. Second `hold_req` ignored. `next_req` -> `piece`=4, `hold_used`=0. Then `hold_req` -> `piece`=2, `hold_piece`=4.
- `next_req` and `hold_req` in the same cycle with `piece`=0 -> `piece`=1, `hold_valid` stays 0.
- `ready` never asserted, `TIMEOUT`=8 -> `bag_timeout`=1 and `newbag` re-pulses every 10 cycles. Then `nreset` pulse mid-WAIT -> all outputs return to reset values.

Source files
------------

// File: rtl/piece_sequencer.sv
// Tetromino sequencer: serves pieces from an active 7-piece bag, prefetches a
// spare bag from the random bag generator, and implements the player hold slot.
module piece_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        nreset,
  output logic        newbag,
  input  logic        ready,
  input  logic [20:0] pieces,
  input  logic        next_req,
  input  logic        hold_req,
  output logic [2:0]  piece,
  output logic        piece_valid,
  output logic [2:0]  preview,
  output logic        preview_valid,
  output logic [2:0]  hold_piece,
  output logic        hold_valid,
  output logic        hold_used,
  output logic        bag_timeout
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} fill_state_t;

  fill_state_t   state, state_nxt;
  logic [CW-1:0] cnt;

  logic [2:0] act [7];
  logic [2:0] spr [7];
  logic [2:0] idx;
  logic       act_v;
  logic       spr_v;
  logic [2:0] hold_q;

  logic waiting, capture, expire;
  logic do_next, do_hold, advance;

  // newbag is high exactly during the first WAIT cycle, which ignores ready.
  assign waiting = (state == S_WAIT) && !newbag;
  assign capture = waiting && ready;
  assign expire  = waiting && !ready && (cnt == CNT_LAST);

  // next_req wins over hold_req; both need a valid current piece.
  assign do_next = next_req && act_v;
  assign do_hold = hold_req && !next_req && act_v && !hold_used;
  assign advance = do_next || (do_hold && !hold_valid);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first, so no path through this block can infer a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (!act_v || !spr_v) state_nxt = S_REQ;
      S_REQ:   state_nxt = S_WAIT;
      S_WAIT: begin
        if (capture)     state_nxt = S_IDLE;
        else if (expire) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      newbag      <= 1'b0;
      cnt         <= '0;
      bag_timeout <= 1'b0;
    end else begin
      newbag <= (state == S_REQ);
      if (state == S_REQ)
        cnt <= '0;
      else if (waiting && !ready && !expire)
        cnt <= cnt + 1'b1;
      if (expire)
        bag_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      // NOTE: bag storage is reset so piece/preview read 0 straight out of reset.
      for (int k = 0; k < 7; k++) begin
        act[k] <= '0;
        spr[k] <= '0;
      end
      idx        <= '0;
      act_v      <= 1'b0;
      spr_v      <= 1'b0;
      hold_q     <= '0;
      hold_valid <= 1'b0;
      hold_used  <= 1'b0;
    end else begin
      // Capture into active only happens while act_v=0, which blocks advance.
      if (capture) begin
        if (!act_v) begin
          for (int k = 0; k < 7; k++) act[k] <= pieces[3*k +: 3];
          act_v <= 1'b1;
          idx   <= '0;
        end else begin
          for (int k = 0; k < 7; k++) spr[k] <= pieces[3*k +: 3];
          spr_v <= 1'b1;
        end
      end

      if (advance) begin
        if (idx < 3'd6) begin
          idx <= idx + 3'd1;
        end else if (spr_v) begin
          for (int k = 0; k < 7; k++) act[k] <= spr[k];
          idx   <= '0;
          spr_v <= 1'b0;
        end else begin
          act_v <= 1'b0;
        end
      end

      if (do_hold) begin
        hold_q     <= act[idx];
        hold_valid <= 1'b1;
        hold_used  <= 1'b1;
        if (hold_valid) act[idx] <= hold_q;
      end

      if (do_next)
        hold_used <= 1'b0;
    end
  end

  assign piece         = act[idx];
  assign piece_valid   = act_v;
  assign preview       = (idx < 3'd6) ? act[idx + 3'd1] : spr[0];
  assign preview_valid = act_v && ((idx < 3'd6) || spr_v);
  assign hold_piece    = hold_q;

endmodule

// File: tb/tb_piece_sequencer.sv
// Self-checking bench for piece_sequencer: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_piece_sequencer;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        nreset;
  logic        newbag;
  logic        ready;
  logic [20:0] pieces;
  logic        next_req;
  logic        hold_req;
  logic [2:0]  piece;
  logic        piece_valid;
  logic [2:0]  preview;
  logic        preview_valid;
  logic [2:0]  hold_piece;
  logic        hold_valid;
  logic        hold_used;
  logic        bag_timeout;

  piece_sequencer #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .nreset        (nreset),
    .newbag        (newbag),
    .ready         (ready),
    .pieces        (pieces),
    .next_req      (next_req),
    .hold_req      (hold_req),
    .piece         (piece),
    .piece_valid   (piece_valid),
    .preview       (preview),
    .preview_valid (preview_valid),
    .hold_piece    (hold_piece),
    .hold_valid    (hold_valid),
    .hold_used     (hold_used),
    .bag_timeout   (bag_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Active bag is a queue of pieces still to serve; spare is a queue or empty.
  // m_age: -2 idle, -1 request pending, >=0 edges since newbag went high.
  logic [2:0] m_act[$];
  logic [2:0] m_spr[$];
  logic [2:0] m_hold;
  bit         m_hv, m_used, m_to, m_fresh;
  int         m_age;

  task automatic m_reset();
    m_act.delete();
    m_spr.delete();
    m_hold  = '0;
    m_hv    = 1'b0;
    m_used  = 1'b0;
    m_to    = 1'b0;
    m_fresh = 1'b1;
    m_age   = -2;
  endtask

  task automatic m_advance();
    void'(m_act.pop_front());
    if (m_act.size() == 0 && m_spr.size() > 0) begin
      m_act = m_spr;
      m_spr.delete();
    end
  endtask

  task automatic m_edge();
    bit have_act, cap, expire, dn, dh;
    logic [2:0] tmp;
    logic [2:0] bag[$];
    have_act = (m_act.size() > 0);
    cap      = (m_age >= 1) && ready;
    expire   = (m_age >= 1) && !ready && (m_age == TO);
    dn       = next_req && have_act;
    dh       = hold_req && !next_req && have_act && !m_used;

    if (m_age == -2) begin
      if (!have_act || m_spr.size() == 0) m_age = -1;
    end else if (m_age == -1) m_age = 0;
    else if (cap) m_age = -2;
    else if (expire) begin
      m_age = -1;
      m_to  = 1'b1;
    end else m_age++;

    if (dn) begin
      m_advance();
      m_used = 1'b0;
    end else if (dh) begin
      if (m_hv) begin
        tmp       = m_act[0];
        m_act[0]  = m_hold;
        m_hold    = tmp;
      end else begin
        m_hold = m_act[0];
        m_hv   = 1'b1;
        m_advance();
      end
      m_used = 1'b1;
    end

    if (cap) begin
      for (int k = 0; k < 7; k++) bag.push_back(pieces[3*k +: 3]);
      if (!have_act) m_act = bag;
      else           m_spr = bag;
      m_fresh = 1'b0;
    end
  endtask

  initial begin : model_proc
    m_reset();
    forever begin
      @(posedge clk or negedge nreset);
      if (!nreset) m_reset();
      else         m_edge();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare_proc
    bit pv;
    forever begin
      @(negedge clk);
      pv = (m_act.size() > 1) || (m_act.size() == 1 && m_spr.size() > 0);
      check("newbag",        32'(newbag),        32'(m_age == 0));
      check("piece_valid",   32'(piece_valid),   32'(m_act.size() > 0));
      check("preview_valid", 32'(preview_valid), 32'(pv));
      check("hold_valid",    32'(hold_valid),    32'(m_hv));
      check("hold_used",     32'(hold_used),     32'(m_used));
      check("hold_piece",    32'(hold_piece),    32'(m_hold));
      check("bag_timeout",   32'(bag_timeout),   32'(m_to));
      if (m_fresh) begin
        check("piece_rst",   32'(piece),   0);
        check("preview_rst", 32'(preview), 0);
      end else begin
        if (m_act.size() > 0) check("piece", 32'(piece), 32'(m_act[0]));
        if (pv) check("preview", 32'(preview), 32'(m_act.size() > 1 ? m_act[1] : m_spr[0]));
      end
    end
  end

  // ---------------- bag generator ----------------
  int          gen_lat   = 3;
  int          gen_len   = 1;
  bit          gen_block = 1'b0;
  bit          gen_rand  = 1'b0;
  bit          gen_noise = 1'b0;
  logic [20:0] gen_bags[$];

  initial begin : bag_gen
    int cd, hold_n;
    ready  = 1'b0;
    pieces = '0;
    cd     = -1;
    hold_n = 0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        ready  = 1'b0;
        cd     = -1;
        hold_n = 0;
      end else begin
        if (hold_n > 0) begin
          hold_n--;
          if (hold_n == 0) ready = 1'b0;
        end
        if (newbag && !gen_block) begin
          cd = gen_rand ? int'($urandom_range(0, 9)) : gen_lat;
          if (gen_bags.size() > 0) pieces = gen_bags.pop_front();
          else                     pieces = 21'($urandom);
        end else if (cd > 0) cd--;
        if (cd == 0) begin
          ready  = 1'b1;
          hold_n = gen_rand ? int'($urandom_range(1, 3)) : gen_len;
          cd     = -1;
        end else if (cd < 0 && gen_noise && hold_n == 0 && $urandom_range(0, 15) == 0) begin
          ready  = 1'b1;
          hold_n = 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic reset_assert();
    @(negedge clk);
    #2 nreset = 1'b0;
    next_req = 1'b0;
    hold_req = 1'b0;
    gen_bags.delete();
    @(negedge clk);
  endtask

  task automatic reset_release();
    #2 nreset = 1'b1;
  endtask

  task automatic strobe(input logic n, input logic h);
    next_req = n;
    hold_req = h;
    @(negedge clk);
    next_req = 1'b0;
    hold_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_pulses(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (newbag) cnt++;
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = piece_valid;
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int cnt;
    bit ok;
    int pulses[$];
    bit bt_first;
    nreset   = 1'b0;
    next_req = 1'b0;
    hold_req = 1'b0;
    idle(2);
    check("rst_piece_valid", 32'(piece_valid), 0);
    check("rst_newbag",      32'(newbag),      0);
    check("rst_hold_valid",  32'(hold_valid),  0);

    // Fill both bags; exactly two newbag pulses.
    gen_bags.push_back(21'o6543210);
    gen_bags.push_back(21'o0123456);
    @(negedge clk);
    reset_release();
    count_pulses(30, cnt);
    check("fill_pulses", 32'(cnt), 2);
    check("fill_piece", 32'(piece), 0);
    check("fill_preview", 32'(preview), 1);
    check("fill_valid", 32'({piece_valid, preview_valid}), 3);

    // Serve through the active bag into the spare.
    for (int k = 1; k <= 6; k++) begin
      strobe(1'b1, 1'b0);
      check("seq_piece", 32'(piece), 32'(k));
    end
    check("seq_preview_spare", 32'(preview), 6);
    gen_block = 1'b1;
    strobe(1'b1, 1'b0);
    check("seq_swap_piece", 32'(piece), 6);
    check("seq_swap_preview", 32'(preview), 5);
    count_pulses(4, cnt);
    check("seq_third_pulse", 32'(cnt), 1);

    // Drain with spare withheld, then release a bag.
    for (int k = 0; k < 7; k++) strobe(1'b1, 1'b0);
    check("drain_valid", 32'(piece_valid), 0);
    strobe(1'b1, 1'b0);
    check("drain_ignored", 32'(piece_valid), 0);
    strobe(1'b0, 1'b1);
    check("drain_hold_ignored", 32'(hold_valid), 0);
    gen_bags.push_back(21'o1111111);
    gen_block = 1'b0;
    wait_valid(40, ok);
    check("refill_arrived", 32'(ok), 1);
    check("refill_piece", 32'(piece), 1);
    check("refill_preview", 32'(preview), 1);

    // Simultaneous requests, then hold behaviour.
    reset_assert();
    gen_bags.push_back(21'o6543210);
    gen_bags.push_back(21'o0123456);
    reset_release();
    idle(30);
    strobe(1'b1, 1'b1);
    check("both_piece", 32'(piece), 1);
    check("both_hold_valid", 32'(hold_valid), 0);
    strobe(1'b1, 1'b0);
    check("pre_hold_piece", 32'(piece), 2);
    strobe(1'b0, 1'b1);
    check("hold1_hold", 32'(hold_piece), 2);
    check("hold1_piece", 32'(piece), 3);
    check("hold1_used", 32'(hold_used), 1);
    strobe(1'b0, 1'b1);
    check("hold2_ignored", 32'({piece, hold_piece}), 32'({3'd3, 3'd2}));
    strobe(1'b1, 1'b0);
    check("hold_next_piece", 32'(piece), 4);
    check("hold_next_used", 32'(hold_used), 0);
    strobe(1'b0, 1'b1);
    check("hold_swap_piece", 32'(piece), 2);
    check("hold_swap_hold", 32'(hold_piece), 4);

    // Generator never answers: timeout and periodic re-request.
    reset_assert();
    gen_block = 1'b1;
    reset_release();
    bt_first = 1'b1;
    for (int c = 1; c <= 60 && pulses.size() < 3; c++) begin
      @(negedge clk);
      if (newbag) begin
        if (pulses.size() == 0) bt_first = bag_timeout;
        pulses.push_back(c);
      end
    end
    check("to_pulse_count", 32'(pulses.size()), 3);
    if (pulses.size() == 3) begin
      check("to_first_pulse", 32'(pulses[0]), 2);
      check("to_period_a", 32'(pulses[1] - pulses[0]), 10);
      check("to_period_b", 32'(pulses[2] - pulses[1]), 10);
    end
    check("to_flag_before", 32'(bt_first), 0);
    check("to_flag_after", 32'(bag_timeout), 1);

    // Reset mid-WAIT returns everything to reset values.
    idle(3);
    #2 nreset = 1'b0;
    @(negedge clk);
    check("midrst_outputs",
          32'({piece, preview, hold_piece, piece_valid, preview_valid, hold_valid,
               hold_used, bag_timeout, newbag}), 0);
    reset_release();
    pulses.delete();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (newbag) pulses.push_back(c);
    end
    check("midrst_restart", 32'(pulses.size() == 1 && pulses[0] == 2), 1);

    // Random traffic against the model.
    gen_block = 1'b0;
    gen_rand  = 1'b1;
    gen_noise = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      next_req = ($urandom_range(0, 3) == 0);
      hold_req = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      if (i == 2000) begin
        reset_assert();
        reset_release();
      end
    end
    next_req = 1'b0;
    hold_req = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
